// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through data cache controller.
// Sits between the MEM stage and a fixed-latency data memory that has no
// handshake, so every memory access is timed by counting MEM_LATENCY cycles.
// Lines are stored big-endian: byte lane k of a line is address word+k.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 3,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_en,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [7:0]  rdata [0:3],
  output logic        freeze,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in [0:3],
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_out [0:3]
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           line_q [LINES];

  logic [INDEX_BITS-1:0] req_idx_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic [INDEX_BITS-1:0] lat_idx_s;
  logic [TAG_W-1:0]      lat_tag_s;
  logic                  hit_s;
  logic                  fill_we_s;
  logic                  line_we_s;
  logic [31:0]           mem_word_s;
  logic [31:0]           hit_word_s;

  // Replace one big-endian byte lane of a word with a store byte.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      2'd3:    res[7:0]   = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  assign req_idx_s  = req_addr[2 +: INDEX_BITS];
  assign req_tag_s  = req_addr[31 -: TAG_W];
  assign lat_idx_s  = addr_q[2 +: INDEX_BITS];
  assign lat_tag_s  = addr_q[31 -: TAG_W];
  assign hit_s      = req_en & valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);
  assign mem_word_s = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};

  // Miss/write FSM next-state, access counter and latched request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fill_we_s = 1'b0;
    line_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_en) begin
          addr_d = {req_addr[31:2], 2'b00};
          if (!req_write) begin
            // Load: a hit completes this cycle, a miss refills the line.
            if (hit_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FILL;
            end
          end else if (!req_byte) begin
            // Word store always writes through and allocates.
            wdata_d = req_wdata;
            state_d = ST_WRITE;
          end else if (hit_s) begin
            wdata_d = merge_byte(line_q[req_idx_s], req_addr[1:0], req_wdata[7:0]);
            state_d = ST_WRITE;
          end else begin
            // Byte store miss: fetch the line first, then retry as a hit.
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (cnt_q == CNT_LAST) begin
          fill_we_s = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        line_we_s = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and latched request registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Line valid bits; cleared only by reset, set on refill or store.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (fill_we_s || line_we_s) begin
      valid_q[lat_idx_s] <= 1'b1;
    end
  end

  // Line data and tags; conflict misses overwrite silently (write-through).
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      line_q[lat_idx_s] <= mem_word_s;
      tag_q[lat_idx_s]  <= lat_tag_s;
    end else if (line_we_s) begin
      line_q[lat_idx_s] <= wdata_q;
      tag_q[lat_idx_s]  <= lat_tag_s;
    end
  end

  // Pipeline stall: held through refills and writes, released on hit or DONE.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      ST_IDLE:  freeze = req_en & ~(~req_write & hit_s);
      ST_FILL:  freeze = 1'b1;
      ST_WRITE: freeze = 1'b1;
      ST_DONE:  freeze = 1'b0;
      default:  freeze = 1'b0;
    endcase
  end

  // Memory address: latched during an access, otherwise follows the request.
  always_comb begin
    mem_addr = 32'h0000_0000;
    if (!rst_b) begin
      mem_addr = 32'h0000_0000;
    end else if ((state_q == ST_FILL) || (state_q == ST_WRITE)) begin
      mem_addr = addr_q;
    end else begin
      mem_addr = {req_addr[31:2], 2'b00};
    end
  end

  assign mem_write_en = (state_q == ST_WRITE);
  assign hit_word_s   = hit_s ? line_q[req_idx_s] : 32'h0000_0000;

  // Unpack store data and hit data onto the big-endian byte-array ports.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdata[k]       = hit_word_s[31 - 8*k -: 8];
      mem_data_in[k] = mem_write_en ? wdata_q[31 - 8*k -: 8] : 8'h00;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with hand-computed expected values.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_en = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [7:0]  rdata [0:3];
  logic        freeze;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in [0:3];
  logic        mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic [31:0] mem_word = 32'h0;
  logic [31:0] rdata_w;
  logic [31:0] mdin_w;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(3), .MEM_LATENCY(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_en       (req_en),
    .req_write    (req_write),
    .req_byte     (req_byte),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .freeze       (freeze),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  assign mem_data_out[0] = mem_word[31:24];
  assign mem_data_out[1] = mem_word[23:16];
  assign mem_data_out[2] = mem_word[15:8];
  assign mem_data_out[3] = mem_word[7:0];
  assign rdata_w = {rdata[0], rdata[1], rdata[2], rdata[3]};
  assign mdin_w  = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};

  // Apply one request (called at posedge+1) and hold it until freeze drops.
  // Reports freeze cycles, write-strobe cycles, last stalled mem_addr,
  // store data seen on the bus and rdata in the released cycle.
  task automatic access(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] wd, output int frz, output int we,
                        output logic [31:0] maddr, output logic [31:0] mdin,
                        output logic [31:0] rd);
    bit done;
    frz = 0; we = 0; maddr = 32'h0; mdin = 32'h0; rd = 32'h0; done = 1'b0;
    req_en = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_write_en) begin
        we++;
        mdin = mdin_w;
      end
      if (freeze) begin
        frz++;
        maddr = mem_addr;
        @(posedge clk); #1;
      end else begin
        rd = rdata_w;
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL access_timeout: freeze still high after 40 cycles addr=%h", a);
      frz = 999;
    end
    @(posedge clk); #1;
    req_en = 1'b0; req_write = 1'b0; req_byte = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; req_en = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b expected 0", freeze); end
    vectors++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_write_en); end
    vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_maddr: got %h expected 0", mem_addr); end
    vectors++; if (mdin_w !== 32'h0) begin errors++; $display("FAIL rst_mdin: got %h expected 0", mdin_w); end
    vectors++; if (rdata_w !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata_w); end
    do_reset();
  endtask

  task automatic test_idle();
    int fz = 0, wc = 0;
    repeat (3) begin
      @(negedge clk);
      if (freeze) fz++;
      if (mem_write_en) wc++;
    end
    @(posedge clk); #1;
    vectors++; if (fz !== 0) begin errors++; $display("FAIL idle_freeze: got %0d expected 0", fz); end
    vectors++; if (wc !== 0) begin errors++; $display("FAIL idle_we: got %0d expected 0", wc); end
  endtask

  task automatic test_load_miss_hit();
    int frz, we; logic [31:0] ma, md, rd;
    mem_word = 32'hDEADBEEF;
    access(1'b0, 1'b0, 32'h100, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL lw_miss_freeze: got %0d expected 5", frz); end
    vectors++; if (ma !== 32'h100) begin errors++; $display("FAIL lw_miss_maddr: got %h expected 100", ma); end
    vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_miss_rdata: got %h expected deadbeef", rd); end
    vectors++; if (we !== 0) begin errors++; $display("FAIL lw_miss_we: got %0d expected 0", we); end
    mem_word = 32'h0;
    access(1'b0, 1'b0, 32'h100, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 0) begin errors++; $display("FAIL lw_hit_freeze: got %0d expected 0", frz); end
    vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hit_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_sb_hit();
    int frz, we; logic [31:0] ma, md, rd;
    access(1'b1, 1'b1, 32'h101, 32'h1234565A, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL sb_hit_freeze: got %0d expected 5", frz); end
    vectors++; if (we !== 4) begin errors++; $display("FAIL sb_hit_we: got %0d expected 4", we); end
    vectors++; if (md !== 32'hDE5ABEEF) begin errors++; $display("FAIL sb_hit_mdin: got %h expected de5abeef", md); end
    vectors++; if (ma !== 32'h100) begin errors++; $display("FAIL sb_hit_maddr: got %h expected 100", ma); end
    access(1'b0, 1'b0, 32'h100, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 0) begin errors++; $display("FAIL sb_reload_freeze: got %0d expected 0", frz); end
    vectors++; if (rd !== 32'hDE5ABEEF) begin errors++; $display("FAIL sb_reload_rdata: got %h expected de5abeef", rd); end
  endtask

  task automatic test_conflict();
    int frz, we; logic [31:0] ma, md, rd;
    do_reset();
    mem_word = 32'h01010101;
    access(1'b0, 1'b0, 32'h100, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL cf_a_freeze: got %0d expected 5", frz); end
    mem_word = 32'h02020202;
    access(1'b0, 1'b0, 32'h120, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL cf_b_freeze: got %0d expected 5", frz); end
    vectors++; if (ma !== 32'h120) begin errors++; $display("FAIL cf_b_maddr: got %h expected 120", ma); end
    vectors++; if (rd !== 32'h02020202) begin errors++; $display("FAIL cf_b_rdata: got %h expected 02020202", rd); end
    mem_word = 32'h03030303;
    access(1'b0, 1'b0, 32'h100, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL cf_evict_freeze: got %0d expected 5", frz); end
    vectors++; if (rd !== 32'h03030303) begin errors++; $display("FAIL cf_evict_rdata: got %h expected 03030303", rd); end
  endtask

  task automatic test_sw_cold();
    int frz, we; logic [31:0] ma, md, rd;
    do_reset();
    mem_word = 32'hFFFFFFFF;
    access(1'b1, 1'b0, 32'h200, 32'h11223344, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL sw_freeze: got %0d expected 5", frz); end
    vectors++; if (we !== 4) begin errors++; $display("FAIL sw_we: got %0d expected 4", we); end
    vectors++; if (md !== 32'h11223344) begin errors++; $display("FAIL sw_mdin: got %h expected 11223344", md); end
    vectors++; if (ma !== 32'h200) begin errors++; $display("FAIL sw_maddr: got %h expected 200", ma); end
    access(1'b0, 1'b0, 32'h200, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 0) begin errors++; $display("FAIL sw_load_freeze: got %0d expected 0", frz); end
    vectors++; if (rd !== 32'h11223344) begin errors++; $display("FAIL sw_load_rdata: got %h expected 11223344", rd); end
  endtask

  task automatic test_sb_miss();
    int frz, we; logic [31:0] ma, md, rd;
    do_reset();
    mem_word = 32'h01020304;
    access(1'b1, 1'b1, 32'h304, 32'h000000AA, frz, we, ma, md, rd);
    vectors++; if (frz !== 10) begin errors++; $display("FAIL sb_miss_freeze: got %0d expected 10", frz); end
    vectors++; if (we !== 4) begin errors++; $display("FAIL sb_miss_we: got %0d expected 4", we); end
    vectors++; if (md !== 32'hAA020304) begin errors++; $display("FAIL sb_miss_mdin: got %h expected aa020304", md); end
    vectors++; if (ma !== 32'h304) begin errors++; $display("FAIL sb_miss_maddr: got %h expected 304", ma); end
    mem_word = 32'h0;
    access(1'b0, 1'b0, 32'h304, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 0) begin errors++; $display("FAIL sb_miss_load_freeze: got %0d expected 0", frz); end
    vectors++; if (rd !== 32'hAA020304) begin errors++; $display("FAIL sb_miss_load_rdata: got %h expected aa020304", rd); end
  endtask

  task automatic test_mid_reset();
    int frz, we; logic [31:0] ma, md, rd;
    do_reset();
    req_en = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = 32'h400; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL mr_we_before: got %b expected 1", mem_write_en); end
    #2 rst_b = 1'b0;
    #1;
    vectors++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL mr_we_drop: got %b expected 0", mem_write_en); end
    vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL mr_maddr: got %h expected 0", mem_addr); end
    req_en = 1'b0; req_write = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    mem_word = 32'h99999999;
    access(1'b0, 1'b0, 32'h400, 32'h0, frz, we, ma, md, rd);
    vectors++; if (frz !== 5) begin errors++; $display("FAIL mr_reload_freeze: got %0d expected 5", frz); end
    vectors++; if (rd !== 32'h99999999) begin errors++; $display("FAIL mr_reload_rdata: got %h expected 99999999", rd); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_miss_hit();
    test_sb_hit();
    test_conflict();
    test_sw_cold();
    test_sb_miss();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
